// File: rtl/instr_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into 32-bit words
// and writes them to instruction memory, holding the core in reset until loaded.
module instr_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  // Words available from BASE_ADDR to the top of memory; 33 bits so the compare cannot wrap.
  localparam logic [32:0] LIMIT = (33'd1 << (ADDR_WIDTH - 2)) - 33'(BASE_ADDR >> 2);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  logic [2:0]  state;
  logic [1:0]  bcnt;
  logic [31:0] count;
  logic [31:0] remaining;
  logic        xfer;
  logic [31:0] hdr_n;

  assign xfer  = byte_valid & byte_ready;
  assign hdr_n = {byte_data, count[23:0]};

  // Every status output is a pure decode of the state register.
  assign byte_ready = (state == S_HDR) || (state == S_DATA);
  assign mem_we     = (state == S_WRITE);
  assign cpu_rst    = (state != S_DONE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bcnt      <= 2'd0;
      count     <= 32'd0;
      remaining <= 32'd0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_HDR;
            bcnt  <= 2'd0;
            count <= 32'd0;
          end
        end
        S_HDR: begin
          if (xfer) begin
            count[{bcnt, 3'b000} +: 8] <= byte_data;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              if (hdr_n == 32'd0) begin
                state <= S_DONE;
              end else if ({1'b0, hdr_n} > LIMIT) begin
                state <= S_ERR;
              end else begin
                state     <= S_DATA;
                mem_addr  <= BASE;
                remaining <= hdr_n;
              end
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            mem_wdata[{bcnt, 3'b000} +: 8] <= byte_data;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) state <= S_WRITE;
          end
        end
        S_WRITE: begin
          remaining <= remaining - 32'd1;
          // Address stays on the last written word once the program is complete.
          if (remaining == 32'd1) begin
            state <= S_DONE;
          end else begin
            mem_addr <= mem_addr + ADDR_WIDTH'(4);
            state    <= S_DATA;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a default-size instance for loading and a
// 16-byte instance for the capacity-overflow case.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        bv0 = 1'b0, bv1 = 1'b0;
  logic [7:0]  bd = 8'h00;
  logic        br0, br1, we0, we1, crst0, crst1, done0, done1, err0, err1;
  logic [11:0] addr0;
  logic [3:0]  addr1;
  logic [31:0] wd0, wd1;

  int nvec = 0;
  int nfail = 0;
  logic [43:0] sb[$];

  always #5 clk = ~clk;

  instr_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .byte_valid(bv0), .byte_data(bd),
    .byte_ready(br0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .cpu_rst(crst0), .done(done0), .error(err0));

  instr_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BASE_ADDR(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .byte_valid(bv1), .byte_data(bd),
    .byte_ready(br1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .cpu_rst(crst1), .done(done1), .error(err1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe pops one expected {addr,data}; no write may overlap byte_ready.
  always @(negedge clk) begin
    if (we0) begin
      if (sb.size() == 0) begin
        check("unexpected_write0", {20'd0, addr0, wd0}, 64'd0);
      end else begin
        logic [43:0] e;
        e = sb.pop_front();
        check("write0", {20'd0, addr0, wd0}, {20'd0, e});
      end
      check("ready_in_write0", {63'd0, br0}, 64'd0);
    end
    if (we1) check("unexpected_write1", {28'd0, addr1, wd1}, 64'd0);
  end

  task automatic send_byte(input int sel, input logic [7:0] b, input bit gap);
    int t;
    t = 0;
    bd = b;
    if (sel == 0) bv0 = 1'b1; else bv1 = 1'b1;
    while (((sel == 0) ? br0 : br1) !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("byte_timeout", 64'(t), 64'd0);
    @(negedge clk);
    bv0 = 1'b0;
    bv1 = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) send_byte(sel, w[8*k +: 8], gap);
  endtask

  task automatic do_start(input int sel);
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    check("hdr_ready", {63'd0, (sel == 0) ? br0 : br1}, 64'd1);
  endtask

  // Full load on dut0: header, words, then exact-cycle checks of the last write and done.
  task automatic run_stream(input logic [31:0] words[$], input bit gap);
    send_word(0, 32'(words.size()), 1'b0);
    if (words.size() == 0) begin
      check("done_after_hdr", {62'd0, done0, crst0}, 64'b10);
      return;
    end
    for (int i = 0; i < words.size(); i++) begin
      sb.push_back({12'(4 * i), words[i]});
      send_word(0, words[i], (i == words.size() - 1) ? 1'b0 : gap);
    end
    check("we_after_last_byte", {63'd0, we0}, 64'd1);
    @(negedge clk);
    check("done_cpu_rst", {62'd0, done0, crst0}, 64'b10);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset0(input string name);
    check(name, {br0, we0, crst0, done0, err0, addr0, wd0},
          {5'b00100, 12'h000, 32'h0});
  endtask

  initial begin
    logic [31:0] prog[$];
    logic [31:0] none[$];
    logic [31:0] one[$];
    prog = '{32'h00A00513, 32'h0000006F};
    none = {};
    one  = '{32'hDEADBEEF};

    #1;
    check_reset0("reset_values0");
    check("reset_values1", {59'd0, br1, we1, crst1, done1, err1}, 64'b00100);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", {63'd0, br0}, 64'd0);

    // Basic two-word load
    do_start(0);
    check("cpu_rst_in_hdr", {63'd0, crst0}, 64'd1);
    run_stream(prog, 1'b0);

    // Same load with byte_valid toggled every other cycle
    do_start(0);
    check("done_cleared_on_reload", {63'd0, done0}, 64'd0);
    run_stream(prog, 1'b1);

    // Empty program
    do_start(0);
    run_stream(none, 1'b0);

    // Capacity overflow on the 4-word instance
    do_start(1);
    send_word(1, 32'd5, 1'b0);
    check("err_state", {61'd0, err1, crst1, done1}, 64'b110);
    repeat (3) @(negedge clk);
    check("err_holds", {62'd0, err1, br1}, 64'b10);
    do_start(1);
    check("err_cleared", {63'd0, err1}, 64'd0);

    // Reset in the middle of word 1, then a clean load
    do_start(0);
    send_word(0, 32'd2, 1'b0);
    send_byte(0, 8'h13, 1'b0);
    send_byte(0, 8'h05, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_reset0("reset_mid_load");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_reset0("no_write_after_reset");
    do_start(0);
    run_stream(prog, 1'b0);

    // Reload from DONE with a single word
    do_start(0);
    check("cpu_rst_reload", {62'd0, crst0, done0}, 64'b10);
    run_stream(one, 1'b0);
    repeat (3) @(negedge clk);
    check("addr_holds_last", {52'd0, addr0}, 64'h000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
